param_sram: RTL and testbench

PARAM_SRAM -- requirements
Module: param_sram

---
 rtl/param_sram.sv | 115 +++++++++++
 tb/tb_param_sram.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/param_sram.sv
// rtl/param_sram.sv - byte-enabled single-port SRAM with self-clearing sweep
//
// Purpose: DEPTH x DATA_WIDTH word memory with per-byte write enables and a
// one-cycle registered read. After reset, or on a clr pulse, the array is
// zeroed by a sweep of one address per cycle. Accesses are accepted only
// while ready is high.
//
// Ports:
//   clk    - single clock, all state changes on the rising edge
//   rst    - asynchronous active-low reset
//   req    - access request, accepted when ready is high
//   wren   - 1 = write, 0 = read
//   addr   - word address
//   wdata  - write data
//   be     - byte enables, bit i covers wdata[8i+7:8i]
//   clr    - single-cycle request to re-zero the whole array
//   rdata  - registered read data, held between reads
//   rvalid - one-cycle pulse marking new rdata
//   ready  - high when the array is idle and accepting accesses

module param_sram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    wren,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    clr,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    ready
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   counter;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // clr takes priority over a request presented in the same cycle.
    logic acc_write;
    logic acc_read;

    assign acc_write = (state == IDLE) && !clr && req && wren;
    assign acc_read  = (state == IDLE) && !clr && req && !wren;

    // Array storage has no reset; the sweep started by reset zeroes it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[counter] <= '0;
        end else if (acc_write) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR;
            counter <= '0;
            ready   <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    rvalid <= 1'b0;
                    if (clr) begin
                        counter <= '0;
                    end else if (&counter) begin
                        // Last address is cleared on this edge.
                        state   <= IDLE;
                        ready   <= 1'b1;
                        counter <= '0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr) begin
                        state   <= CLEAR;
                        ready   <= 1'b0;
                        counter <= '0;
                        rvalid  <= 1'b0;
                    end else if (acc_read) begin
                        rdata  <= mem[addr];
                        rvalid <= 1'b1;
                    end else begin
                        rvalid <= 1'b0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    ready   <= 1'b0;
                    counter <= '0;
                    rvalid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_sram.sv
// tb/tb_param_sram.sv - scoreboard testbench for param_sram

module tb_param_sram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wren = 1'b0;
    logic [3:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  be = '0;
    logic        clr = 1'b0;
    logic [15:0] rdata;
    logic        rvalid;
    logic        ready;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    param_sram #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .req(req), .wren(wren), .addr(addr),
        .wdata(wdata), .be(be), .clr(clr), .rdata(rdata),
        .rvalid(rvalid), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        req = 1'b1; wren = 1'b1; addr = a; wdata = d; be = b;
        cyc();
        req = 1'b0; wren = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] exp);
        exp_q.push_back(exp);
        req = 1'b1; wren = 1'b0; addr = a;
        cyc();
        req = 1'b0;
    endtask

    // Count edges until ready rises; bounded so a stuck sweep still ends.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 40) begin
            cyc();
            n++;
        end
    endtask

    // Monitor: every rvalid pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rvalid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_rvalid actual rdata=%0h required no rvalid", rdata);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (rdata !== e) begin
                        n_errors++;
                        $display("FAIL read_data actual=%0h required=%0h", rdata, e);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        #2 rst = 1'b0;
        #1;
        chk("reset_rdata", 32'(rdata), 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_ready", 32'(ready), 32'h0);
        cyc();
        cyc();
        rst = 1'b1;
        wait_ready(n);
        chk("init_sweep_cycles", 32'(n), 32'd16);

        rd(4'd3, 16'h0000);
        wr(4'd1, 16'hAAAA, 2'b11);
        rd(4'd1, 16'hAAAA);
        wr(4'd1, 16'h5555, 2'b01);
        rd(4'd1, 16'hAA55);
        wr(4'd1, 16'hFFFF, 2'b00);
        rd(4'd1, 16'hAA55);
        wr(4'd15, 16'h1234, 2'b11);
        wr(4'd0, 16'hBEEF, 2'b11);
        rd(4'd15, 16'h1234);
        rd(4'd0, 16'hBEEF);
        rd(4'd14, 16'h0000);
        rd(4'd0, 16'hBEEF);
        cyc();
        chk("rvalid_low_idle", 32'(rvalid), 32'h0);
        chk("rdata_hold", 32'(rdata), 32'hBEEF);

        // clr wins over a read in the same cycle
        clr = 1'b1; req = 1'b1; wren = 1'b0; addr = 4'd15;
        cyc();
        clr = 1'b0;
        chk("clr_ready_low", 32'(ready), 32'h0);
        // requests during the sweep are ignored
        addr = 4'd2;
        for (int i = 0; i < 4; i++) cyc();
        req = 1'b0;
        // clr during the sweep restarts it from address 0
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        wait_ready(n);
        chk("restart_sweep_cycles", 32'(n), 32'd16);
        rd(4'd15, 16'h0000);
        rd(4'd0, 16'h0000);
        rd(4'd1, 16'h0000);

        // reset right after a read is accepted: no rvalid must appear
        wr(4'd5, 16'h7777, 2'b11);
        req = 1'b1; wren = 1'b0; addr = 4'd5;
        cyc();
        req = 1'b0;
        rst = 1'b0;
        #1;
        chk("midread_rvalid", 32'(rvalid), 32'h0);
        chk("midread_rdata", 32'(rdata), 32'h0);
        chk("midread_ready", 32'(ready), 32'h0);
        cyc();
        cyc();
        rst = 1'b1;
        wait_ready(n);
        chk("post_reset_sweep_cycles", 32'(n), 32'd16);
        rd(4'd5, 16'h0000);

        for (int i = 0; i < 4; i++) cyc();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
